// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: in-order FIFO of
// {pc, inst, fetch-exception} entries with flush on redirect.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  input  logic          in_exc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_exc,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } entry_t;

  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PONE = {{(AW-1){1'b0}}, 1'b1};

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            push;
  logic            pop;
  entry_t          head_e;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign head_e    = mem_q[head_q];
  assign out_pc    = out_valid ? head_e.pc   : 32'h0;
  assign out_inst  = out_valid ? head_e.inst : 32'h0;
  assign out_exc   = out_valid ? head_e.exc  : 1'b0;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{pc: in_pc, inst: in_inst, exc: in_exc};
        tail_d        = tail_q + PONE;
      end
      if (pop)
        head_d = head_q + PONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
